prefetch_sequencer: RTL

Issues code-fetch read requests to the memory side and packs the returned qwords into 136-bit entries for the prefetch FIFO. It keeps the current linear fetch address and the remaining segment-limit byte count, and throttles on FIFO occupancy. It raises the limit (#GP) and page-fault (#PF) marker writes toward the FIFO. It aborts cleanly on pr_reset, draining any in-flight beats.

---
 rtl/prefetch_sequencer_if.sv | 39 +++
 rtl/prefetch_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_sequencer_if.sv
// rtl/prefetch_sequencer_if.sv - memory-side request/response bundle for the prefetch sequencer
//
// Purpose: groups the code-fetch read request channel and the beat response
//          channel between the prefetch sequencer and the memory side.
// Signals:
//   req_valid     sequencer -> memory  read request valid
//   req_ready     memory -> sequencer  request accepted
//   req_address   sequencer -> memory  qword-aligned fetch address
//   resp_valid    memory -> sequencer  response beat valid (2 beats per request)
//   resp_data     memory -> sequencer  beat data, little-endian
//   resp_pf_fault memory -> sequencer  page fault, qualifies resp_valid, ends transaction
// Modports: master = sequencer side, slave = memory side.

interface prefetch_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_address;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        resp_pf_fault;

   modport master (
      output req_valid,
      output req_address,
      input  req_ready,
      input  resp_valid,
      input  resp_data,
      input  resp_pf_fault
   );

   modport slave (
      input  req_valid,
      input  req_address,
      output req_ready,
      output resp_valid,
      output resp_data,
      output resp_pf_fault
   );
endinterface

// File: rtl/prefetch_sequencer.sv
// rtl/prefetch_sequencer.sv - code-fetch request sequencer packing qword beats into prefetch FIFO entries
//
// Purpose: tracks the linear fetch address and remaining segment-limit bytes,
//          issues one read per FIFO entry when occupancy allows, packs the two
//          returned beats into a 136-bit entry and raises limit / page-fault
//          markers. pr_reset and restart_do abort cleanly, draining beats still
//          owed by the memory side.
// Optional: define PREFETCH_SEQ_STATS_EN to add o_stat_requests and
//           o_stat_stall_cycles.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   i_pr_reset                      abort fetching, discard in-flight data
//   i_restart_do                    load new stream (1-cycle pulse)
//   i_restart_linear[31:0]          start linear address
//   i_restart_remaining[31:0]       bytes allowed before limit fault
//   i_prefetchfifo_used[4:0]        FIFO occupancy (bit4 = full)
//   mem                             request/response bundle (master side)
//   o_prefetchfifo_write_do         write packed entry
//   o_prefetchfifo_write_data[135:0] {cnt1,data1,cnt0,data0}
//   o_prefetchfifo_signal_limit_do  limit-fault marker pulse
//   o_prefetchfifo_signal_pf_do     page-fault marker pulse
//   o_stat_requests[31:0]           (stats build) accepted requests
//   o_stat_stall_cycles[31:0]       (stats build) FIFO-throttled idle cycles

module prefetch_sequencer #(
   parameter int FIFO_THRESHOLD = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_pr_reset,
   input  logic                 i_restart_do,
   input  logic [31:0]          i_restart_linear,
   input  logic [31:0]          i_restart_remaining,
   input  logic [4:0]           i_prefetchfifo_used,
   prefetch_sequencer_if.master mem,
   output logic                 o_prefetchfifo_write_do,
   output logic [135:0]         o_prefetchfifo_write_data,
   output logic                 o_prefetchfifo_signal_limit_do,
   output logic                 o_prefetchfifo_signal_pf_do
`ifdef PREFETCH_SEQ_STATS_EN
   ,
   output logic [31:0]          o_stat_requests,
   output logic [31:0]          o_stat_stall_cycles
`endif
);

   localparam logic [4:0] LP_THRESHOLD = 5'(FIFO_THRESHOLD);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_BEAT0,
      ST_BEAT1,
      ST_DRAIN0,
      ST_DRAIN1,
      ST_STOPPED
   } state_t;

   state_t        r_state;
   logic [31:0]   r_linear;
   logic [31:0]   r_remaining;
   logic          r_active;
   logic [3:0]    r_cnt0;
   logic [63:0]   r_data0;
   logic          r_req_valid;
   logic [31:0]   r_req_address;
   logic          r_write_do;
   logic [135:0]  r_write_data;
   logic          r_limit_do;
   logic          r_pf_do;

   logic [2:0]    w_off;
   logic [3:0]    w_head;
   logic [3:0]    w_cnt0;
   logic [63:0]   w_data0;
   logic [31:0]   w_rem_after0;
   logic [3:0]    w_cnt1;
   logic [63:0]   w_data1;
   logic [31:0]   w_step;
   logic          w_abort;
   logic          w_fifo_ok;
   logic          w_beat;
   logic          w_fault;

   // First beat: bytes from the current offset to the end of the qword, capped by the limit.
   assign w_off        = r_linear[2:0];
   assign w_head       = 4'd8 - {1'b0, w_off};
   assign w_cnt0       = (r_remaining < {28'd0, w_head}) ? r_remaining[3:0] : w_head;
   assign w_data0      = mem.resp_data >> {w_off, 3'b000};

   // Second beat: whatever the limit still allows, possibly nothing (beat is still consumed).
   assign w_rem_after0 = r_remaining - {28'd0, r_cnt0};
   assign w_cnt1       = (r_remaining <= {28'd0, r_cnt0}) ? 4'd0 :
                         ((w_rem_after0 < 32'd8) ? w_rem_after0[3:0] : 4'd8);
   assign w_data1      = (w_cnt1 == 4'd0) ? 64'd0 : mem.resp_data;
   assign w_step       = {28'd0, r_cnt0} + {28'd0, w_cnt1};

   // A restart while a transaction is outstanding behaves like pr_reset for the FSM.
   assign w_abort      = i_pr_reset | i_restart_do;
   assign w_fifo_ok    = (i_prefetchfifo_used < LP_THRESHOLD) && !i_prefetchfifo_used[4];
   assign w_beat       = mem.resp_valid;
   assign w_fault      = mem.resp_valid & mem.resp_pf_fault;

   assign mem.req_valid                  = r_req_valid;
   assign mem.req_address                = r_req_address;
   assign o_prefetchfifo_write_do        = r_write_do;
   assign o_prefetchfifo_write_data      = r_write_data;
   assign o_prefetchfifo_signal_limit_do = r_limit_do;
   assign o_prefetchfifo_signal_pf_do    = r_pf_do;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_linear      <= 32'd0;
         r_remaining   <= 32'd0;
         r_active      <= 1'b0;
         r_cnt0        <= 4'd0;
         r_data0       <= 64'd0;
         r_req_valid   <= 1'b0;
         r_req_address <= 32'd0;
         r_write_do    <= 1'b0;
         r_write_data  <= 136'd0;
         r_limit_do    <= 1'b0;
         r_pf_do       <= 1'b0;
      end else begin
         r_write_do <= 1'b0;
         r_limit_do <= 1'b0;
         r_pf_do    <= 1'b0;

         if (i_pr_reset) begin
            r_active <= 1'b0;
         end
         // Restart after pr_reset in the same cycle: the new stream wins.
         if (i_restart_do) begin
            r_linear    <= i_restart_linear;
            r_remaining <= i_restart_remaining;
            r_active    <= 1'b1;
         end

         unique case (r_state)
            ST_IDLE: begin
               if (!w_abort && r_active) begin
                  if (r_remaining == 32'd0) begin
                     r_limit_do <= 1'b1;
                     r_state    <= ST_STOPPED;
                  end else if (w_fifo_ok) begin
                     r_req_valid   <= 1'b1;
                     r_req_address <= {r_linear[31:3], 3'b000};
                     r_state       <= ST_REQ;
                  end
               end
            end

            ST_REQ: begin
               if (mem.req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= w_abort ? ST_DRAIN0 : ST_BEAT0;
               end else if (w_abort) begin
                  r_req_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end

            ST_BEAT0: begin
               if (w_abort) begin
                  // A beat arriving in the abort cycle is already consumed.
                  if (w_fault)     r_state <= ST_IDLE;
                  else if (w_beat) r_state <= ST_DRAIN1;
                  else             r_state <= ST_DRAIN0;
               end else if (w_fault) begin
                  r_pf_do <= 1'b1;
                  r_state <= ST_STOPPED;
               end else if (w_beat) begin
                  r_cnt0  <= w_cnt0;
                  r_data0 <= w_data0;
                  r_state <= ST_BEAT1;
               end
            end

            ST_BEAT1: begin
               if (w_abort) begin
                  r_state <= w_beat ? ST_IDLE : ST_DRAIN1;
               end else if (w_fault) begin
                  r_pf_do <= 1'b1;
                  r_state <= ST_STOPPED;
               end else if (w_beat) begin
                  r_write_do   <= 1'b1;
                  r_write_data <= {w_cnt1, w_data1, r_cnt0, r_data0};
                  r_linear     <= r_linear + w_step;
                  r_remaining  <= r_remaining - w_step;
                  r_state      <= ST_IDLE;
               end
            end

            // Draining keeps consuming owed beats even if another abort arrives.
            ST_DRAIN0: begin
               if (w_fault)     r_state <= ST_IDLE;
               else if (w_beat) r_state <= ST_DRAIN1;
            end

            ST_DRAIN1: begin
               if (w_beat) r_state <= ST_IDLE;
            end

            ST_STOPPED: begin
               if (w_abort) r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef PREFETCH_SEQ_STATS_EN
   logic [31:0] r_stat_requests;
   logic [31:0] r_stat_stall_cycles;
   logic        w_handshake;
   logic        w_stall;

   assign w_handshake = (r_state == ST_REQ) && mem.req_ready;
   assign w_stall     = (r_state == ST_IDLE) && r_active && (r_remaining != 32'd0) && !w_fifo_ok;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_requests     <= 32'd0;
         r_stat_stall_cycles <= 32'd0;
      end else begin
         if (w_handshake) r_stat_requests     <= r_stat_requests + 32'd1;
         if (w_stall)     r_stat_stall_cycles <= r_stat_stall_cycles + 32'd1;
      end
   end

   assign o_stat_requests     = r_stat_requests;
   assign o_stat_stall_cycles = r_stat_stall_cycles;
`endif

endmodule
